// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode constants and FSM state encoding shared by the
// pipeline-control block and its hazard-detect sub-module.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_J   = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1110;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use detection.
// Ports:
//   id_valid, id_rs, id_rt     - ID stage instruction and its source registers
//   ex_valid, ex_mem_read,
//   ex_rd                      - EX stage instruction, load flag, destination
//   load_use                   - ID reads the register an EX load is writing
// Register 0 is hard-wired zero and never causes a stall.
import pipe_ctrl_pkg::*;

module hazard_detect (
  input  logic       id_valid,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [2:0] ex_rd,
  output logic       load_use
);

  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != 3'd0) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush control with a multi-cycle multiplier.
// Parameter:
//   MUL_LAT       - multiply latency in cycles (2..15)
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   id_*, ex_*    - ID/EX stage instruction info used for hazard detection
//   branch_taken  - EX resolved a taken branch/jump
//   pc_write, ifid_write, idex_bubble, flush_ifid - pipeline controls
//   mul_start     - one-cycle multiplier start strobe
//   hilo_write    - one-cycle HI/LO commit strobe
//   busy          - multiply in flight
//   stall_cnt     - cycles with pc_write low; live only when
//                   PIPE_CTRL_STALL_CNT_EN is defined, otherwise constant 0
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [2:0]  ex_rd,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush_ifid,
  output logic        mul_start,
  output logic        hilo_write,
  output logic        busy,
  output logic [15:0] stall_cnt
);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       load_use;

  hazard_detect u_hazard (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    mul_start   = 1'b0;
    hilo_write  = 1'b0;
    busy        = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          flush_ifid  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_valid && (id_opcode == OP_MUL)) begin
          mul_start = 1'b1;
          state_nxt = MUL_WAIT;
          cnt_nxt   = 4'(MUL_LAT - 1);
        end
      end
      MUL_WAIT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        busy        = 1'b1;
        if (cnt == 4'd0) begin
          hilo_write = 1'b1;
          state_nxt  = RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
    // Reset is asynchronous, so the combinational strobes are forced to the
    // RUN-idle pattern while it is held rather than waiting for a clock edge.
    if (rst) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      flush_ifid  = 1'b0;
      mul_start   = 1'b0;
      hilo_write  = 1'b0;
      busy        = 1'b0;
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!pc_write && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed, table-driven self-checking bench for pipe_ctrl.
// Output vectors are packed as
// {pc_write, ifid_write, idex_bubble, flush_ifid, mul_start, hilo_write, busy}.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [2:0]  id_rs, id_rt;
  logic        ex_valid, ex_mem_read;
  logic [2:0]  ex_rd;
  logic        branch_taken;
  logic        pc_write, ifid_write, idex_bubble, flush_ifid;
  logic        mul_start, hilo_write, busy;
  logic [15:0] stall_cnt;
  logic [6:0]  outs;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] O_IDLE  = 7'b1100000;
  localparam logic [6:0] O_LU    = 7'b0010000;
  localparam logic [6:0] O_BR    = 7'b1111000;
  localparam logic [6:0] O_ISSUE = 7'b1100100;
  localparam logic [6:0] O_WAIT  = 7'b0010001;
  localparam logic [6:0] O_DONE  = 7'b0010011;

`ifdef PIPE_CTRL_STALL_CNT_EN
  localparam logic [15:0] EXP_STALLS = 16'd9;
`else
  localparam logic [15:0] EXP_STALLS = 16'd0;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.MUL_LAT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .flush_ifid   (flush_ifid),
    .mul_start    (mul_start),
    .hilo_write   (hilo_write),
    .busy         (busy),
    .stall_cnt    (stall_cnt)
  );

  assign outs = {pc_write, ifid_write, idex_bubble, flush_ifid,
                 mul_start, hilo_write, busy};

  typedef struct {
    string      name;
    logic       iv;
    logic [3:0] op;
    logic [2:0] rs, rt;
    logic       exv, exmr;
    logic [2:0] exrd;
    logic       br;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] op, input logic [2:0] rs,
                       input logic [2:0] rt, input logic exv, input logic exmr,
                       input logic [2:0] exrd, input logic br);
    id_valid = iv; id_opcode = op; id_rs = rs; id_rt = rt;
    ex_valid = exv; ex_mem_read = exmr; ex_rd = exrd; branch_taken = br;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  // Drive a cycle's inputs just after the falling edge and sample 1 ns later.
  task automatic cyc(input string name, input logic [6:0] exp);
    #1;
    chk(name, outs, exp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"idle",        0, 4'h0, 3'd0, 3'd0, 0, 0, 3'd0, 0, O_IDLE};
    vecs[1]  = '{"lu_rs",       1, 4'h0, 3'd3, 3'd1, 1, 1, 3'd3, 0, O_LU};
    vecs[2]  = '{"lu_r0",       1, 4'h0, 3'd0, 3'd1, 1, 1, 3'd0, 0, O_IDLE};
    vecs[3]  = '{"lu_rt",       1, 4'h0, 3'd1, 3'd5, 1, 1, 3'd5, 0, O_LU};
    vecs[4]  = '{"ex_invalid",  1, 4'h0, 3'd3, 3'd1, 0, 1, 3'd3, 0, O_IDLE};
    vecs[5]  = '{"not_load",    1, 4'h0, 3'd3, 3'd1, 1, 0, 3'd3, 0, O_IDLE};
    vecs[6]  = '{"id_invalid",  0, 4'h0, 3'd3, 3'd1, 1, 1, 3'd3, 0, O_IDLE};
    vecs[7]  = '{"branch",      0, 4'h0, 3'd0, 3'd0, 0, 0, 3'd0, 1, O_BR};
    vecs[8]  = '{"br_lu_mul",   1, 4'hE, 3'd3, 3'd1, 1, 1, 3'd3, 1, O_BR};
    vecs[9]  = '{"mul_novalid", 0, 4'hE, 3'd0, 3'd0, 0, 0, 3'd0, 0, O_IDLE};
    vecs[10] = '{"lu_over_mul", 1, 4'hE, 3'd2, 3'd1, 1, 1, 3'd2, 0, O_LU};
    vecs[11] = '{"no_match",    1, 4'h0, 3'd3, 3'd5, 1, 1, 3'd4, 0, O_IDLE};

    // Asynchronous reset with a live load-use on the inputs: outputs gated.
    rst = 1'b0;
    drive(1'b1, 4'h0, 3'd3, 3'd1, 1'b1, 1'b1, 3'd3, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("reset_outs", outs, O_IDLE);
    chk16("reset_stall", stall_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);

    for (int unsigned i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].op, vecs[i].rs, vecs[i].rt,
            vecs[i].exv, vecs[i].exmr, vecs[i].exrd, vecs[i].br);
      cyc(vecs[i].name, vecs[i].exp);
    end
    idle();

    // Two back-to-back multiplies plus one load-use: 4 + 4 + 1 stall cycles.
    do_reset();
    drive(1'b1, 4'hE, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc("mul1_issue", O_ISSUE);
    // Branch and load-use during the wait must be ignored.
    drive(1'b1, 4'hE, 3'd3, 3'd1, 1'b1, 1'b1, 3'd3, 1'b1);
    cyc("mul1_wait1", O_WAIT);
    cyc("mul1_wait2", O_WAIT);
    cyc("mul1_wait3", O_WAIT);
    cyc("mul1_done", O_DONE);
    drive(1'b1, 4'hE, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc("mul2_issue", O_ISSUE);
    idle();
    cyc("mul2_wait1", O_WAIT);
    cyc("mul2_wait2", O_WAIT);
    cyc("mul2_wait3", O_WAIT);
    cyc("mul2_done", O_DONE);
    drive(1'b1, 4'h0, 3'd3, 3'd1, 1'b1, 1'b1, 3'd3, 1'b0);
    cyc("post_mul_lu", O_LU);
    idle();
    cyc("post_idle", O_IDLE);
    chk16("stall_count", stall_cnt, EXP_STALLS);

    // Reset in the middle of MUL_WAIT aborts the multiply.
    do_reset();
    drive(1'b1, 4'hE, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc("abort_issue", O_ISSUE);
    idle();
    cyc("abort_wait1", O_WAIT);
    #2 rst = 1'b1;
    #1;
    chk("abort_rst_outs", outs, O_IDLE);
    chk16("abort_rst_stall", stall_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      cyc("abort_no_hilo", O_IDLE);
    end
    chk16("abort_stall_after", stall_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, multiply latency in cycles (legal 2..15).
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous reset, active-high
  id_valid  in  1  ID stage holds a real instruction
  id_opcode  in  4  opcode of the ID instruction
  id_rs  in  3  ID source register rs
  id_rt  in  3  ID source register rt
  ex_valid  in  1  EX stage holds a real instruction
  ex_mem_read  in  1  EX instruction is a load
  ex_rd  in  3  EX destination register
  branch_taken  in  1  EX resolved a taken branch/jump
  pc_write  out  1  PC may update
  ifid_write  out  1  IF/ID register may update
  idex_bubble  out  1  insert NOP into ID/EX
  flush_ifid  out  1  clear IF/ID to NOP
  mul_start  out  1  one-cycle multiplier start strobe
  hilo_write  out  1  one-cycle HI/LO commit strobe
  busy  out  1  multiply in flight
  stall_cnt  out  16  stall-cycle count (macro-dependent, REQ-019)

Function
REQ-003 SHALL implement FSM states RUN and MUL_WAIT plus a 4-bit down-counter.
REQ-004 load_use SHALL be id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt); register 0 never causes a stall.
REQ-005 In RUN with branch_taken=1: flush_ifid=1, idex_bubble=1, pc_write=1, ifid_write=1, mul_start=0; branch overrides load_use and multiply issue in the same cycle.
REQ-006 In RUN with branch_taken=0 and load_use=1: pc_write=0, ifid_write=0, idex_bubble=1 for exactly that cycle; no mul_start.
REQ-007 In RUN with no branch, no load_use, id_valid=1, id_opcode==OP_MUL: mul_start=1 combinationally that cycle; next state MUL_WAIT, counter loaded with MUL_LAT-1.
REQ-008 In MUL_WAIT: pc_write=0, ifid_write=0, idex_bubble=1, flush_ifid=0, busy=1; counter decrements each cycle; branch_taken and load_use ignored.
REQ-009 In MUL_WAIT with counter==0: hilo_write=1 for that cycle, next state RUN.
REQ-010 Consequently mul_start to hilo_write spans exactly MUL_LAT cycles; ID is frozen MUL_LAT cycles total including the issue cycle's successors.
REQ-011 Otherwise in RUN: pc_write=1, ifid_write=1, all other outputs 0.
REQ-012 Back-to-back MUL: second MUL in ID on the cycle RUN is re-entered SHALL issue normally (mul_start that cycle), no idle gap.
REQ-013 OP_MUL with id_valid=0 SHALL NOT start a multiply.

Reset
REQ-014 rst=1 SHALL asynchronously force state RUN, counter 0, stall_cnt 0.
REQ-015 During reset outputs SHALL be pc_write=1, ifid_write=1, all others 0 (combinational terms gated by rst).
REQ-016 Reset in MUL_WAIT SHALL abort the multiply; no hilo_write is ever produced for it.

Configuration
REQ-017 Macro PIPE_CTRL_STALL_CNT_EN SHALL control the stall counter.
REQ-018 With it defined: stall_cnt increments by 1 each cycle pc_write==0, saturating at 16'hFFFF, cleared only by rst.
REQ-019 Without it: stall_cnt SHALL be constant 0, no counter flops synthesised; port remains.

Structure
REQ-020 Shared package SHALL hold opcode constants OP_LW=4'b1000, OP_SW=4'b1001, OP_BEQ=4'b1010, OP_J=4'b1011, OP_MUL=4'b1110, and the FSM state encoding.
REQ-021 Hazard detection (REQ-004) SHALL be sub-module hazard_detect, purely combinational; FSM, counter and output muxing stay in pipe_ctrl.

Verification
REQ-022 ex_valid=1, ex_mem_read=1, ex_rd=3, id_valid=1, id_rs=3 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; same with ex_rd=0 -> no stall.
REQ-023 MUL_LAT=4, id_opcode=4'b1110 with id_valid=1 at cycle 0 -> mul_start at cycle 0, busy/stall cycles 1-4, hilo_write at cycle 4, RUN at cycle 5.
REQ-024 branch_taken=1 concurrently with load_use and ID MUL -> flush_ifid=1, idex_bubble=1, pc_write=1, mul_start=0.
REQ-025 rst asserted at cycle 2 of MUL_WAIT -> immediate RUN outputs, no hilo_write afterwards, stall_cnt=0.
REQ-026 Macro defined, two back-to-back MULs with MUL_LAT=4 plus one load-use -> stall_cnt=9; macro undefined -> stall_cnt=0.
